// File: rtl/sram_pkg.sv
// Shared widths, bus-op encoding and packed-field helpers for the external SRAM port.
package sram_pkg;

  localparam int ADDR_W  = 18;
  localparam int DATA_W  = 16;
  localparam int MAX_REQ = 8;

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_READ,
    OP_WRITE
  } busOp_e;

  // Callers zero-pad their packed vectors to MAX_REQ fields before extracting.
  function automatic logic [ADDR_W-1:0] addrField(input logic [MAX_REQ*ADDR_W-1:0] vec,
                                                  input int idx);
    return vec[idx*ADDR_W +: ADDR_W];
  endfunction

  function automatic logic [DATA_W-1:0] dataField(input logic [MAX_REQ*DATA_W-1:0] vec,
                                                  input int idx);
    return vec[idx*DATA_W +: DATA_W];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first requester at or after the pointer wins; the pointer
// moves past whichever requester the owner reports as granted.
module rr_arbiter #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] req,
  input  logic             advance,
  input  logic [WIDTH-1:0] advGrant,
  output logic [WIDTH-1:0] grant
);

  localparam int PTR_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] nextPtr;
  logic             found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (!found && req[i] && (i >= int'(ptr))) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int i = 0; i < WIDTH; i++) begin
      if (!found && req[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    nextPtr = ptr;
    for (int i = 0; i < WIDTH; i++) begin
      if (advGrant[i]) nextPtr = (i == WIDTH - 1) ? '0 : PTR_W'(i + 1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ptr <= '0;
    else if (advance) ptr <= nextPtr;
  end

endmodule

// File: rtl/sram_arbiter.sv
// SRAM arbiter: requester 0 has strict priority, the rest share round-robin,
// with a starvation override for the last requester and a read-to-write bubble.
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int NUM_REQ      = 3,
  parameter int STARVE_LIMIT = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  input  logic [NUM_REQ*2-1:0]      req_be,
  output logic [NUM_REQ-1:0]        ack,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [DATA_W-1:0]         ram_dout,
  input  logic [DATA_W-1:0]         ram_din,
  output logic                      ram_ce,
  output logic                      ram_oe,
  output logic                      ram_we,
  output logic                      ram_lb,
  output logic                      ram_hb
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam int LAST  = NUM_REQ - 1;

  logic [NUM_REQ-2:0]        rrGrant;
  logic [NUM_REQ-1:0]        winOneHot;
  logic [IDX_W-1:0]          winIdx;
  logic                      starveWin;
  logic                      bubble;
  logic                      accepted;
  logic                      accWe;
  logic [ADDR_W-1:0]         selAddr;
  logic [DATA_W-1:0]         selData;
  logic [1:0]                selBe;
  logic [MAX_REQ*ADDR_W-1:0] addrPad;
  logic [MAX_REQ*DATA_W-1:0] dataPad;
  logic [CNT_W-1:0]          starveCnt;
  logic [NUM_REQ-1:0]        rdTag;
  busOp_e                    lastOp;

  always_comb begin
    addrPad = '0;
    addrPad[NUM_REQ*ADDR_W-1:0] = req_addr;
    dataPad = '0;
    dataPad[NUM_REQ*DATA_W-1:0] = req_wdata;
  end

  assign starveWin = req[LAST] && (starveCnt >= CNT_W'(STARVE_LIMIT));

  always_comb begin
    winOneHot = '0;
    if (starveWin) winOneHot[LAST] = 1'b1;
    else if (req[0]) winOneHot[0] = 1'b1;
    else winOneHot = {rrGrant, 1'b0};
  end

  always_comb begin
    winIdx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winOneHot[i]) winIdx = IDX_W'(i);
    end
  end

  // A write right behind a read is held off one cycle so the SRAM stops driving first.
  assign bubble   = (lastOp == OP_READ) && (|winOneHot) && req_we[winIdx];
  assign ack      = (reset || bubble) ? '0 : winOneHot;
  assign accepted = |ack;
  assign accWe    = req_we[winIdx];
  assign selAddr  = addrField(addrPad, int'(winIdx));
  assign selData  = dataField(dataPad, int'(winIdx));
  assign selBe    = req_be[int'(winIdx)*2 +: 2];

  rr_arbiter #(
    .WIDTH(NUM_REQ - 1)
  ) uRr (
    .clk     (clk),
    .reset   (reset),
    .req     (req[NUM_REQ-1:1]),
    .advance (|ack[NUM_REQ-1:1]),
    .advGrant(ack[NUM_REQ-1:1]),
    .grant   (rrGrant)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      lastOp    <= OP_IDLE;
      starveCnt <= '0;
      rdTag     <= '0;
      rvalid    <= '0;
      rdata     <= '0;
      ram_addr  <= '0;
      ram_dout  <= '0;
      ram_ce    <= 1'b0;
      ram_oe    <= 1'b0;
      ram_we    <= 1'b0;
      ram_lb    <= 1'b0;
      ram_hb    <= 1'b0;
    end else begin
      lastOp <= accepted ? (accWe ? OP_WRITE : OP_READ) : OP_IDLE;

      if (!req[LAST] || ack[LAST]) starveCnt <= '0;
      else if (starveCnt < CNT_W'(STARVE_LIMIT)) starveCnt <= starveCnt + 1'b1;

      // ram_din is captured at the end of the pin cycle, so rvalid lands two cycles after ack.
      rdTag  <= ack & ~req_we;
      rvalid <= rdTag;
      if (|rdTag) rdata <= ram_din;

      ram_ce <= accepted;
      ram_oe <= accepted && !accWe;
      ram_we <= accepted && accWe;
      if (accepted) begin
        ram_addr         <= selAddr;
        {ram_hb, ram_lb} <= selBe;
        if (accWe) ram_dout <= selData;
      end else begin
        {ram_hb, ram_lb} <= 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized bench for sram_arbiter against a cycle-level model of the arbitration rules.
module tb_sram_arbiter;
  import sram_pkg::*;

  localparam int NR    = 3;
  localparam int LIMIT = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NR-1:0]        req, req_we, ack, rvalid;
  logic [NR*ADDR_W-1:0] req_addr;
  logic [NR*DATA_W-1:0] req_wdata;
  logic [NR*2-1:0]      req_be;
  logic [DATA_W-1:0]    rdata, ram_dout, ram_din;
  logic [ADDR_W-1:0]    ram_addr;
  logic                 ram_ce, ram_oe, ram_we, ram_lb, ram_hb;

  sram_arbiter #(.NUM_REQ(NR), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be), .ack(ack), .rvalid(rvalid), .rdata(rdata),
    .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_din(ram_din), .ram_ce(ram_ce),
    .ram_oe(ram_oe), .ram_we(ram_we), .ram_lb(ram_lb), .ram_hb(ram_hb)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ramModel(input logic [17:0] a);
    if (a == 18'h02040) return 16'hBEEF;
    return a[15:0] ^ {a[17:16], 14'h1234};
  endfunction

  assign ram_din = ramModel(ram_addr);

  // Requester side: each pending request is held until acked or withdrawn.
  bit          pend[NR];
  bit          pWe[NR];
  logic [17:0] pAddr[NR];
  logic [15:0] pData[NR];
  logic [1:0]  pBe[NR];

  // Reference state
  int          mPtr, mStarve;
  bit          mLastRead, p1Valid;
  int          p1Who;
  logic [17:0] p1Addr;
  logic        expCe, expOe, expWe;
  logic [17:0] expAddr;
  logic [15:0] expDout, expRdata;
  logic [1:0]  expLanes;
  logic [2:0]  expRvalid;

  int nTests = 0;
  int nFail  = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic setReq(input int i, input bit we, input logic [17:0] a, input logic [15:0] d,
                        input logic [1:0] be);
    pend[i]  = 1'b1;
    pWe[i]   = we;
    pAddr[i] = a;
    pData[i] = d;
    pBe[i]   = be;
  endtask

  task automatic renew(input int i, input bit we);
    if (!pend[i])
      setReq(i, we, 18'($urandom), 16'($urandom), 2'($urandom_range(1, 3)));
  endtask

  task automatic runCycle(input bit doReset);
    int          win, acked, r;
    bit          bub;
    logic [31:0] expAck;
    reset = doReset;
    for (int i = 0; i < NR; i++) begin
      req[i]                        = pend[i];
      req_we[i]                     = pWe[i];
      req_addr[i*ADDR_W +: ADDR_W]  = pAddr[i];
      req_wdata[i*DATA_W +: DATA_W] = pData[i];
      req_be[i*2 +: 2]              = pBe[i];
    end
    #1;
    win = -1;
    bub = 1'b0;
    if (!doReset) begin
      if (mStarve >= LIMIT && pend[NR-1]) win = NR - 1;
      else if (pend[0]) win = 0;
      else begin
        for (int k = 0; k < NR - 1; k++) begin
          r = 1 + (mPtr - 1 + k) % (NR - 1);
          if (win < 0 && pend[r]) win = r;
        end
      end
      if (win >= 0 && mLastRead && pWe[win]) bub = 1'b1;
    end
    acked  = (win >= 0 && !bub) ? win : -1;
    expAck = (acked >= 0) ? (32'd1 << acked) : 32'd0;
    checkVal("ack", 32'(ack), expAck);

    @(posedge clk);
    if (doReset) begin
      mPtr = 1; mStarve = 0; mLastRead = 0; p1Valid = 0;
      expCe = 0; expOe = 0; expWe = 0; expAddr = '0; expDout = '0;
      expLanes = '0; expRvalid = '0; expRdata = '0;
    end else begin
      expRvalid = p1Valid ? 3'(1 << p1Who) : 3'b000;
      if (p1Valid) expRdata = ramModel(p1Addr);
      p1Valid = 1'b0;
      if (acked >= 0) begin
        p1Valid  = !pWe[acked];
        p1Who    = acked;
        p1Addr   = pAddr[acked];
        expAddr  = pAddr[acked];
        expLanes = pBe[acked];
        if (pWe[acked]) expDout = pData[acked];
      end
      expCe = (acked >= 0);
      expOe = (acked >= 0) && !pWe[acked];
      expWe = (acked >= 0) && pWe[acked];
      if (pend[NR-1] && acked != NR - 1) mStarve = (mStarve + 1 > LIMIT) ? LIMIT : mStarve + 1;
      else mStarve = 0;
      if (acked >= 1) mPtr = (acked == NR - 1) ? 1 : acked + 1;
      mLastRead = p1Valid;
      if (acked >= 0) pend[acked] = 1'b0;
    end

    @(negedge clk);
    checkVal("ram_ce", 32'(ram_ce), 32'(expCe));
    checkVal("ram_oe", 32'(ram_oe), 32'(expOe));
    checkVal("ram_we", 32'(ram_we), 32'(expWe));
    checkVal("ram_addr", 32'(ram_addr), 32'(expAddr));
    checkVal("ram_dout", 32'(ram_dout), 32'(expDout));
    checkVal("rvalid", 32'(rvalid), 32'(expRvalid));
    if (expCe || doReset) checkVal("lanes", 32'({ram_hb, ram_lb}), 32'(expLanes));
    if (expRvalid != 0 || doReset) checkVal("rdata", 32'(rdata), 32'(expRdata));
  endtask

  initial begin
    for (int i = 0; i < NR; i++) setReq(i, 1'b0, '0, '0, 2'b00);
    for (int i = 0; i < NR; i++) pend[i] = 1'b0;
    mPtr = 1; mStarve = 0; mLastRead = 0; p1Valid = 0; p1Who = 0; p1Addr = '0;

    // Reset then idle
    runCycle(1'b1);
    runCycle(1'b1);
    repeat (2) runCycle(1'b0);

    // Single read returning 0xBEEF
    setReq(1, 1'b0, 18'h02040, 16'h0000, 2'b11);
    repeat (4) runCycle(1'b0);

    // Priority then round-robin
    runCycle(1'b1);
    for (int c = 0; c < 6; c++) begin
      renew(0, 1'b0); renew(1, 1'b0); renew(2, 1'b0);
      runCycle(1'b0);
    end
    for (int c = 0; c < 8; c++) begin
      renew(1, 1'b0); renew(2, 1'b0);
      runCycle(1'b0);
    end
    for (int i = 0; i < NR; i++) pend[i] = 1'b0;

    // Starvation override against requester 0
    runCycle(1'b1);
    for (int c = 0; c < 12; c++) begin
      renew(0, 1'b0); renew(2, 1'b0);
      runCycle(1'b0);
    end
    for (int i = 0; i < NR; i++) pend[i] = 1'b0;

    // Read-to-write turnaround
    runCycle(1'b1);
    setReq(1, 1'b0, 18'h00100, 16'h0000, 2'b11);
    setReq(2, 1'b1, 18'h00200, 16'hCAFE, 2'b10);
    repeat (5) runCycle(1'b0);

    // Reset while a read is in flight
    setReq(1, 1'b0, 18'h00333, 16'h0000, 2'b01);
    runCycle(1'b0);
    runCycle(1'b1);
    setReq(1, 1'b0, 18'h00444, 16'h0000, 2'b11);
    setReq(2, 1'b0, 18'h00555, 16'h0000, 2'b11);
    repeat (4) runCycle(1'b0);

    // Random traffic with withdrawals and occasional resets
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) renew(i, 1'($urandom_range(0, 1)));
        else if (pend[i] && $urandom_range(0, 15) == 0) pend[i] = 1'b0;
      end
      runCycle($urandom_range(0, 99) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single external 16-bit asynchronous SRAM between NUM_REQ requesters.
- Requester 0 is the background fetch engine. It has strict priority and needs deterministic fetch timing.
- Requesters 1..NUM_REQ-1 (sprite fetch, CPU/loader) share the remaining cycles round-robin.
- Owns the ram_* pins, returns read data with fixed latency, and includes a starvation guard for the last requester (CPU).

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- STARVE_LIMIT, 64, cycles requester NUM_REQ-1 may wait with req high before it is forced to win one grant.
- ADDR_W, 18, SRAM word address width.
- DATA_W, 16, SRAM data width.

Ports:
- clk  in  1  system clock (the fetch clock, not clkPixel).
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester access request; held until ack.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_W  packed word addresses; requester i in bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  packed write data.
- req_be  in  NUM_REQ*2  packed byte enables {hb, lb}.
- ack  out  NUM_REQ  one-hot, combinational; request accepted this cycle.
- rvalid  out  NUM_REQ  one-hot; rdata is valid for that requester.
- rdata  out  DATA_W  read data, shared by all requesters.
- ram_addr  out  ADDR_W  registered.
- ram_dout  out  DATA_W  registered.
- ram_din  in  DATA_W  SRAM read data.
- ram_ce  out  1  active-high logical, registered.
- ram_oe  out  1  active-high logical, registered.
- ram_we  out  1  active-high logical, registered.
- ram_lb  out  1  byte lane enable, registered.
- ram_hb  out  1  byte lane enable, registered.

Behaviour:
- Reset:
  - ack, rvalid, ram_ce, ram_oe, ram_we, ram_lb and ram_hb are 0; ram_addr, ram_dout and rdata are 0.
  - Round-robin pointer = 1; starvation counter = 0; in-flight read tags cleared.
  - A read in flight at reset never produces rvalid.
- Arbitration, evaluated each cycle from current req, at most one ack:
  - (a) If the starvation counter is at or above STARVE_LIMIT and req[NUM_REQ-1] is high, requester NUM_REQ-1 wins.
  - (b) Otherwise, if req[0] is high, requester 0 wins.
  - (c) Otherwise, the first requester at or after the round-robin pointer among 1..NUM_REQ-1 with req high wins.
  - The pointer advances to winner+1, wrapping from NUM_REQ-1 to 1, only on a grant in case (c) or case (a).
- Turnaround:
  - If the previous cycle's bus op was a read and the winner is a write, no ack is issued this cycle (bubble) and the pins go idle.
  - The same winner is re-evaluated next cycle; it may lose to a new higher-priority read.
  - Write-to-read and same-direction back-to-back accesses need no bubble.
- Pin timing, cycle T = ack cycle:
  - T+1, read: ram_ce=1, ram_oe=1, ram_we=0, ram_addr=addr, lanes=be.
  - T+1, write: ram_ce=1, ram_oe=0, ram_we=1, ram_dout=wdata.
  - Idle: ram_ce, ram_oe and ram_we = 0; ram_addr and ram_dout hold their last values.
- Read return:
  - ram_din is sampled at the end of T+1.
  - rdata is driven and rvalid[i] is high for exactly one cycle at T+2.
  - Read latency is therefore fixed at 2 cycles from ack; a read may be acked every cycle (pipelined).
  - Writes produce no rvalid.
- Starvation counter:
  - Increments, saturating at STARVE_LIMIT, on each cycle req[NUM_REQ-1] is high and not acked.
  - Cleared on ack[NUM_REQ-1] or when req[NUM_REQ-1] is low.
- Handshake: a requester must hold req, req_we, req_addr, req_wdata and req_be stable until its ack cycle. Dropping req before ack is allowed and is treated as a withdrawal.
- Simultaneous events: starvation override beats requester 0 for exactly one grant; requester 0 wins again the next cycle.

Decomposition:
- Shared package sram_pkg:
  - ADDR_W and DATA_W constants.
  - Bus-op enum {OP_IDLE, OP_READ, OP_WRITE}, used for turnaround tracking.
  - Helper function that extracts field i from a packed vector.
- One sub-module, rr_arbiter: NUM_REQ-1 requests in, one-hot grant out, pointer register, advance enable. Parameterised by width; reusable by the sprite engine.

Test Plan:
- Reset then idle:
  - Stimulus: reset high 2 cycles, then no req.
  - Required: all ram_* controls 0, no ack, no rvalid.
- Single read:
  - Stimulus: req[1]=1, addr=0x02040, ram_din model returns 0xBEEF.
  - Required: ack[1] at T; ram_addr=0x02040, ce=oe=1 at T+1; rvalid[1]=1 and rdata=0xBEEF at T+2.
- Priority and round-robin:
  - Stimulus: req[0..2] high continuously, then req[0] drops.
  - Required: ack[0] every cycle while req[0] is high; after it drops, acks alternate 1, 2, 1, 2.
- Starvation:
  - Stimulus: STARVE_LIMIT=4, req[0] and req[2] held high.
  - Required: ack[2] on the 5th waiting cycle, exactly once, then ack[0] resumes.
- Turnaround:
  - Stimulus: read by requester 1 acked at T, write by requester 2 pending.
  - Required: no ack at T+1; ack[2] at T+2; ram_we=1 with ram_dout=wdata at T+3.
- Reset mid-read:
  - Stimulus: reset at T+1 after a read ack.
  - Required: no rvalid at T+2; round-robin pointer = 1 afterwards.
